udp_tx_buffer: RTL and testbench

Ping-pong payload buffer that sits directly upstream of the UDP/IP transmit framer. It accepts 32-bit payload words from the application over a valid/ready handshake and stores up to two complete frames. It tracks the framer's `tx_state` to bind one full frame to each transmission. It drives the framer's `datain`, `tx_data_length` and `tx_total_length` from the frame bound to the current transmission.

---
 rtl/udp_tx_pkg.sv | 35 +++
 rtl/tx_bank_ram.sv | 40 ++++
 rtl/udp_tx_buffer.sv | 152 +++++++++++++++
 tb/tb_udp_tx_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit ping-pong buffer: framer state codes,
// bank bookkeeping types and the header-length arithmetic.
package udp_tx_pkg;

  localparam int DATA_W = 32;
  localparam int RAM_AW = 9;

  localparam logic [3:0] TX_IDLE      = 4'd0;
  localparam logic [3:0] TX_START     = 4'd1;
  localparam logic [3:0] TX_APPENDCRC = 4'd7;

  localparam int UDP_HDR_BYTES    = 8;
  localparam int IP_UDP_HDR_BYTES = 28;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_e;

  typedef struct packed {
    logic [15:0] data_len;
    logic [15:0] total_len;
  } tx_len_t;

  // UDP and IP length fields for a frame of `words` 32-bit payload words.
  function automatic tx_len_t frame_len(input logic [7:0] words);
    tx_len_t l;
    l.data_len  = 16'(UDP_HDR_BYTES) + {6'd0, words, 2'b00};
    l.total_len = 16'(IP_UDP_HDR_BYTES) + {6'd0, words, 2'b00};
    return l;
  endfunction

endpackage

// File: rtl/tx_bank_ram.sv
// 512x32 simple dual-port payload memory, addressed {bank, word[7:0]}.
// One write port and one registered read port.
module tx_bank_ram
  import udp_tx_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**RAM_AW];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wdata;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_tx_buffer.sv
// Two-bank payload buffer feeding the UDP/IP transmit framer: the application
// fills one bank while the framer reads the other, one frame per transmission.
module udp_tx_buffer
  import udp_tx_pkg::*;
#(
  parameter int MAX_WORDS = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        wr_trunc,
  input  logic [3:0]  tx_state,
  input  logic [8:0]  ram_rd_addr,
  output logic [31:0] datain,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        tx_underrun
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

  bank_state_e bank_state_q [2];
  bank_state_e bank_state_d [2];
  logic [7:0]  count_q [2];
  logic [7:0]  count_d [2];

  logic        wb_q, wb_d;
  logic        rb_q, rb_d;
  logic        pad_q, pad_d;
  logic [3:0]  prev_state_q;
  logic        wr_ready_q, wr_ready_d;
  logic        wr_trunc_q, wr_trunc_d;
  logic        tx_underrun_q, tx_underrun_d;
  tx_len_t     len_q, len_d;

  logic        start_det;
  logic        end_det;
  logic        wr_accept;
  logic [7:0]  next_count;
  logic        ram_we;
  logic [8:0]  ram_waddr;
  logic [31:0] ram_rdata;
  logic        unused_rd_msb;

  assign unused_rd_msb = ram_rd_addr[8];

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    bank_state_d  = bank_state_q;
    count_d       = count_q;
    wb_d          = wb_q;
    rb_d          = rb_q;
    pad_d         = pad_q;
    len_d         = len_q;
    wr_trunc_d    = 1'b0;
    tx_underrun_d = 1'b0;

    start_det  = (tx_state == TX_START) && (prev_state_q == TX_IDLE);
    end_det    = (tx_state == TX_IDLE) && (prev_state_q == TX_APPENDCRC);
    wr_accept  = wr_valid && wr_ready_q;
    next_count = count_q[wb_q] + 8'd1;
    ram_we     = wr_accept;
    ram_waddr  = {wb_q, next_count};

    // Write side only ever touches an EMPTY/FILLING bank, so it never collides
    // with the FULL bank taken at start or the READING bank released at end.
    if (wr_accept) begin
      count_d[wb_q]      = next_count;
      bank_state_d[wb_q] = BANK_FILLING;
      if (wr_last || (next_count == MAX_W8)) begin
        bank_state_d[wb_q] = BANK_FULL;
        wb_d               = ~wb_q;
        wr_trunc_d         = ~wr_last;
      end
    end

    // Eligibility uses the registered state, so a bank closing on this edge pads.
    if (start_det) begin
      if (bank_state_q[rb_q] == BANK_FULL) begin
        bank_state_d[rb_q] = BANK_READING;
        len_d              = frame_len(count_q[rb_q]);
        pad_d              = 1'b0;
      end else begin
        pad_d         = 1'b1;
        len_d         = frame_len(8'd1);
        tx_underrun_d = 1'b1;
      end
    end

    if (end_det) begin
      if (bank_state_q[rb_q] == BANK_READING) begin
        bank_state_d[rb_q] = BANK_EMPTY;
        count_d[rb_q]      = '0;
        rb_d               = ~rb_q;
      end
      pad_d = 1'b0;
    end

    wr_ready_d = (bank_state_d[wb_d] == BANK_EMPTY) ||
                 (bank_state_d[wb_d] == BANK_FILLING);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_q[b] <= BANK_EMPTY;
        count_q[b]      <= '0;
      end
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      pad_q         <= 1'b0;
      prev_state_q  <= TX_IDLE;
      wr_ready_q    <= 1'b1;
      wr_trunc_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      len_q         <= frame_len(8'd1);
    end else begin
      bank_state_q  <= bank_state_d;
      count_q       <= count_d;
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      pad_q         <= pad_d;
      prev_state_q  <= tx_state;
      wr_ready_q    <= wr_ready_d;
      wr_trunc_q    <= wr_trunc_d;
      tx_underrun_q <= tx_underrun_d;
      len_q         <= len_d;
    end
  end

  tx_bank_ram u_ram (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wdata   (wr_data),
    .rd_addr ({rb_q, ram_rd_addr[7:0]}),
    .rd_data (ram_rdata)
  );

  assign wr_ready        = wr_ready_q;
  assign wr_trunc        = wr_trunc_q;
  assign tx_underrun     = tx_underrun_q;
  assign tx_data_length  = len_q.data_len;
  assign tx_total_length = len_q.total_len;
  assign datain          = pad_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_udp_tx_buffer.sv
// Scoreboard bench for udp_tx_buffer: a queue-of-frames reference model predicts
// handshake, pulses, lengths and read data; a negedge monitor compares.
module tb_udp_tx_buffer;

  localparam int MAX_WORDS = 255;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_last;
  logic        wr_ready;
  logic        wr_trunc;
  logic [3:0]  tx_state;
  logic [8:0]  ram_rd_addr;
  logic [31:0] datain;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        tx_underrun;

  always #5 clk = ~clk;

  udp_tx_buffer #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk             (clk),
    .clr             (clr),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_last         (wr_last),
    .wr_ready        (wr_ready),
    .wr_trunc        (wr_trunc),
    .tx_state        (tx_state),
    .ram_rd_addr     (ram_rd_addr),
    .datain          (datain),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .tx_underrun     (tx_underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: complete frames waiting, words in arrival order, frame on air.
  int          pend_len [$];
  logic [31:0] stream_q [$];
  logic [31:0] cur_words [$];
  int          fill_n;
  int          m_cur_n;
  bit          m_reading;
  bit          m_pad;
  logic [3:0]  m_prev;
  logic [15:0] m_dl, m_tl;
  bit          exp_trunc, exp_underrun;
  logic [31:0] rd_exp_q [$];
  bit          chk_rd;
  bit          mon_en;

  // Write source and framer-side read request.
  logic [31:0] src_data [$];
  bit          src_last [$];
  bit          gaps;
  bit          rd_issue;

  function automatic bit exp_ready();
    return (pend_len.size() + (m_reading ? 1 : 0)) < 2;
  endfunction

  task automatic model_reset();
    pend_len.delete(); stream_q.delete(); cur_words.delete(); rd_exp_q.delete();
    src_data.delete(); src_last.delete();
    fill_n = 0; m_cur_n = 0; m_reading = 0; m_pad = 0; m_prev = 4'd0;
    m_dl = 16'd12; m_tl = 16'd32;
    exp_trunc = 0; exp_underrun = 0; chk_rd = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit ready_pre, start_e, end_e;
    int idx;
    ready_pre    = exp_ready();
    start_e      = (tx_state == 4'd1) && (m_prev == 4'd0);
    end_e        = (tx_state == 4'd0) && (m_prev == 4'd7);
    m_prev       = tx_state;
    exp_trunc    = 0;
    exp_underrun = 0;
    chk_rd       = 0;
    if (start_e) begin
      if (pend_len.size() > 0 && !m_reading) begin
        m_cur_n = pend_len.pop_front();
        cur_words.delete();
        for (int i = 0; i < m_cur_n; i++)
          if (stream_q.size() > 0) cur_words.push_back(stream_q.pop_front());
        m_reading = 1;
        m_pad     = 0;
        m_dl      = 16'(8 + 4 * m_cur_n);
        m_tl      = 16'(28 + 4 * m_cur_n);
      end else begin
        m_pad        = 1;
        exp_underrun = 1;
        m_dl         = 16'd12;
        m_tl         = 16'd32;
      end
    end
    if (end_e) begin
      m_reading = 0;
      m_pad     = 0;
    end
    if (rd_issue) begin
      idx = int'(ram_rd_addr[7:0]);
      if (m_pad) rd_exp_q.push_back(32'd0);
      else if (idx >= 1 && idx <= cur_words.size()) rd_exp_q.push_back(cur_words[idx-1]);
      else rd_exp_q.push_back(32'hDEAD_BEEF);
      chk_rd = 1;
    end
    if (wr_valid && ready_pre) begin
      stream_q.push_back(wr_data);
      fill_n++;
      if (src_data.size() > 0) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
      end
      if (wr_last || fill_n == MAX_WORDS) begin
        exp_trunc = !wr_last;
        pend_len.push_back(fill_n);
        fill_n = 0;
      end
    end
  endtask

  task automatic drive_wr();
    if (src_data.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
      wr_valid = 1'b1;
      wr_data  = src_data[0];
      wr_last  = src_last[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = $urandom;
      wr_last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    drive_wr();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic queue_frame(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      src_data.push_back($urandom);
      src_last.push_back(last && (i == n - 1));
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (src_data.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    if (src_data.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still queued, expected 0", src_data.size());
      src_data.delete();
      src_last.delete();
    end
  endtask

  task automatic finish_send();
    int n;
    n = m_pad ? 1 : m_cur_n;
    tx_state = 4'd2; tick();
    for (int i = 1; i <= n; i++) begin
      tx_state    = 4'd3;
      ram_rd_addr = {1'($urandom_range(0, 1)), 8'(i)};
      rd_issue    = 1;
      tick();
    end
    rd_issue = 0;
    tx_state = 4'd6; tick();
    tx_state = 4'd7; tick();
    tx_state = 4'd0; tick();
  endtask

  task automatic send_frame(input int exp_dl, input int exp_tl);
    tx_state = 4'd1;
    tick();
    if (exp_dl > 0) begin
      check("start_data_len", 32'(tx_data_length), exp_dl);
      check("start_total_len", 32'(tx_total_length), exp_tl);
    end
    finish_send();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_ready"}, 32'(wr_ready), 1);
    check({tag, "_wr_trunc"}, 32'(wr_trunc), 0);
    check({tag, "_underrun"}, 32'(tx_underrun), 0);
    check({tag, "_datain"}, datain, 0);
    check({tag, "_data_len"}, 32'(tx_data_length), 12);
    check({tag, "_total_len"}, 32'(tx_total_length), 32);
  endtask

  always @(negedge clk) begin
    if (mon_en && !clr) begin
      check("wr_ready", 32'(wr_ready), 32'(exp_ready()));
      check("wr_trunc", 32'(wr_trunc), 32'(exp_trunc));
      check("tx_underrun", 32'(tx_underrun), 32'(exp_underrun));
      check("tx_data_length", 32'(tx_data_length), 32'(m_dl));
      check("tx_total_length", 32'(tx_total_length), 32'(m_tl));
      if (chk_rd) begin
        if (rd_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL datain_scoreboard: got 0x%0h, expected queue empty", datain);
        end else begin
          check("datain", datain, rd_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    clr = 1'b1; wr_data = '0; wr_valid = 0; wr_last = 0;
    tx_state = 4'd0; ram_rd_addr = '0; rd_issue = 0; gaps = 0; mon_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    clr    = 1'b0;
    mon_en = 1;
    tick();

    // Basic 4-word frame.
    src_data = '{32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677};
    src_last = '{0, 0, 0, 1};
    drain(50);
    send_frame(24, 44);

    // Ping-pong: A (2 words) and B (3 words) back to back.
    queue_frame(2, 1);
    queue_frame(3, 1);
    drain(50);
    check("pp_ready_both_full", 32'(wr_ready), 0);
    send_frame(16, 36);
    check("pp_ready_after_end", 32'(wr_ready), 1);
    send_frame(20, 40);

    // Truncation at MAX_WORDS, word 256 spills into the other bank.
    queue_frame(256, 0);
    drain(400);
    send_frame(1028, 1048);
    queue_frame(1, 1);
    drain(50);
    send_frame(16, 36);

    // Underrun with both banks empty, then a normal frame.
    send_frame(12, 32);
    queue_frame(3, 1);
    drain(50);
    send_frame(20, 40);

    // Reset in the middle of a transmission with a second frame pending.
    queue_frame(2, 1);
    queue_frame(2, 1);
    drain(50);
    tx_state = 4'd1; tick();
    tx_state = 4'd2; tick();
    tx_state = 4'd3; ram_rd_addr = 9'd1; rd_issue = 1; tick();
    rd_issue = 0;
    tx_state = 4'd6; tick();
    mon_en = 0;
    wr_valid = 0;
    clr = 1'b1;
    model_reset();
    #1;
    check_reset_values("midclr");
    tx_state = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    clr    = 1'b0;
    mon_en = 1;
    send_frame(12, 32);

    // Frame closes on the same edge as start detect: start pads.
    queue_frame(2, 1);
    tick();
    tx_state = 4'd1;
    tick();
    check("close_on_start_len", 32'(tx_data_length), 12);
    check("close_on_start_total", 32'(tx_total_length), 32);
    finish_send();
    send_frame(16, 36);

    // Randomized traffic: writes overlap transmissions, occasional underruns.
    gaps = 1;
    for (int it = 0; it < 40; it++) begin
      if (src_data.size() == 0)
        queue_frame($urandom_range(1, 12), 1);
      repeat ($urandom_range(0, 6)) tick();
      if (pend_len.size() > 0 || $urandom_range(0, 7) == 0)
        send_frame(0, 0);
    end
    gaps  = 0;
    guard = 0;
    while ((src_data.size() > 0 || pend_len.size() > 0) && guard < 100) begin
      if (pend_len.size() > 0) send_frame(0, 0);
      else tick();
      guard++;
    end
    if (src_data.size() > 0 || pend_len.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL final_flush: %0d frames pending, expected 0", pend_len.size());
    end
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
